// File: rtl/req_queue4_pkg.sv
// Shared types for the four-requester queue: requester index, queue entry,
// and the grant-shape helper used by the legality check.
package req_queue4_pkg;

  localparam int NUM_REQ = 4;
  localparam int ENTRY_W = 8;

  typedef logic [1:0] req_idx_t;

  typedef struct packed {
    logic [ENTRY_W-1:0] data;
    req_idx_t           src;
  } q_entry_t;

  // True when more than one grant bit is set.
  function automatic logic gnt_multi_hot(input logic [NUM_REQ-1:0] g);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return (g & (g - one)) != '0;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-requester FIFO. The caller only pushes when not full and only pops
// when not empty; head is the current read-pointer entry.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/req_queue4.sv
// Four per-requester FIFOs feeding a single output register through an
// external arbiter; illegal grants are ignored and latched in o_gnt_err.
module req_queue4
  import req_queue4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_push_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   i_push_data,
  output logic [NUM_REQ-1:0]              o_push_ready,
  input  logic                            i_en,
  output logic [NUM_REQ-1:0]              o_req,
  input  logic [NUM_REQ-1:0]              i_gnt,
  output logic                            o_out_valid,
  output logic [WIDTH-1:0]                o_out_data,
  output logic [1:0]                      o_out_src,
  input  logic                            i_out_ready,
  output logic                            o_gnt_err
);

  logic [NUM_REQ-1:0]            w_full;
  logic [NUM_REQ-1:0]            w_empty;
  logic [NUM_REQ-1:0]            w_push;
  logic [NUM_REQ-1:0]            w_pop;
  logic [NUM_REQ-1:0][WIDTH-1:0] w_head;
  logic                          w_can_load;
  logic                          w_gnt_illegal;
  logic                          w_pop_any;
  req_idx_t                      w_pop_idx;
  logic [WIDTH-1:0]              w_pop_data;

  logic                          r_out_valid;
  logic [WIDTH-1:0]              r_out_data;
  req_idx_t                      r_out_src;
  logic                          r_gnt_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
      req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push[gi]),
        .i_data  (i_push_data[gi]),
        .i_pop   (w_pop[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_head  (w_head[gi])
      );
    end
  endgenerate

  // Requests come only from FIFO occupancy registers, never from push inputs.
  assign w_can_load   = !r_out_valid || i_out_ready;
  assign o_req        = ~w_empty & {NUM_REQ{i_en && w_can_load}};
  assign o_push_ready = ~w_full;
  assign w_push       = i_push_valid & ~w_full;

  assign w_gnt_illegal = gnt_multi_hot(i_gnt) || ((i_gnt & ~o_req) != '0);
  assign w_pop         = w_gnt_illegal ? '0 : (i_gnt & o_req);
  assign w_pop_any     = |w_pop;

  always_comb begin
    w_pop_idx  = '0;
    w_pop_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pop[k]) begin
        w_pop_idx  = req_idx_t'(k);
        w_pop_data = w_head[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_gnt_err   <= 1'b0;
    end else begin
      if (w_pop_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pop_data;
        r_out_src   <= w_pop_idx;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_gnt_illegal) r_gnt_err <= 1'b1;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;
  assign o_gnt_err   = r_gnt_err;

endmodule

// File: doc/req_queue4.md
REQ_QUEUE4 -- requirements
Module: req_queue4

Interface
REQ-001 Parameter WIDTH, default 8, payload bits per entry SHALL be as stated.
REQ-002 Parameter DEPTH, default 4, entries per requester FIFO (power of two, >=2) SHALL be as stated.
REQ-003 clock  input  1  single clock; all state SHALL update on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 push_valid  input  4  per-requester push strobe.
REQ-006 push_data  input  4xWIDTH  per-requester payload, packed [3:0][WIDTH-1:0].
REQ-007 push_ready  output  4  per-requester space available.
REQ-008 en  input  1  global enable for request presentation.
REQ-009 req  output  4  request vector to the downstream 4-way rotating priority arbiter.
REQ-010 gnt  input  4  one-hot grant returned by the arbiter in the same cycle.
REQ-011 out_valid  output  1  issued entry valid.
REQ-012 out_data  output  WIDTH  issued payload.
REQ-013 out_src  output  2  index of the requester whose entry is issued.
REQ-014 out_ready  input  1  consumer accepts the issued entry.
REQ-015 gnt_err  output  1  sticky flag, illegal grant seen.

Function
REQ-016 Each requester i SHALL own an independent FIFO of DEPTH x WIDTH with an occupancy count of 0..DEPTH.
REQ-017 push_ready[i] SHALL be 1 exactly when count[i] < DEPTH, with no same-cycle pop credit.
REQ-018 A push SHALL occur when push_valid[i] && push_ready[i]; a push_valid with push_ready low SHALL be dropped with no state change.
REQ-019 can_load SHALL be !out_valid || out_ready.
REQ-020 req[i] SHALL equal (count[i] != 0) && en && can_load, decoded from registers only with no combinational path from push_* to req.
REQ-021 A pop of FIFO i SHALL occur when gnt == one-hot(i) and req[i] == 1.
REQ-022 On a pop, the head entry SHALL load into out_data, out_src SHALL load i, and out_valid SHALL be set on the next edge, giving one-cycle latency from grant to out_valid.
REQ-023 When out_valid && out_ready with no pop, out_valid SHALL clear on the next edge.
REQ-024 When out_valid && out_ready with a pop in the same cycle, the output register SHALL reload and out_valid SHALL stay 1, giving back-to-back issue.
REQ-025 While out_valid && !out_ready, out_data and out_src SHALL remain stable.
REQ-026 A simultaneous push and pop on the same FIFO SHALL both take effect, leave count unchanged, and preserve FIFO order.
REQ-027 A push into an empty FIFO SHALL raise req no earlier than the following cycle.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 An illegal grant SHALL be ignored (no pop, no output change) and SHALL set gnt_err until reset; an illegal grant is gnt with more than one bit set, or gnt[i]=1 with req[i]=0.
REQ-030 gnt == 0 SHALL be legal and SHALL produce no pop.

Reset
REQ-031 Reset assertion SHALL, asynchronously: zero all counts and pointers; set req=0, out_valid=0, out_data=0, out_src=0, gnt_err=0; set push_ready=4'b1111.
REQ-032 Reset mid-operation SHALL discard all queued and issued entries; FIFO storage contents need not be cleared.
REQ-033 Reset deassertion SHALL take effect on the first posedge clock with reset high.

Structure
REQ-034 A shared package SHALL hold: NUM_REQ=4; the requester-index typedef (2-bit); a queue-entry struct {data, src}.
REQ-035 A single-requester FIFO sub-module named req_fifo (push/pop/full/empty/head) SHALL be instantiated four times.
REQ-036 Grant legality check, output register and gnt_err SHALL reside in req_queue4.

Verification
REQ-037 Reset, then push 0xA1 on requester 2; with gnt driven one-hot to req -> req=4'b0100 one cycle after push, out_valid=1, out_data=0xA1, out_src=2 one cycle after gnt.
REQ-038 Push 4 entries to requester 0 with no grants -> push_ready[0]=0, and a 5th push is dropped; then grant 4 times with out_ready=1 -> out_data sequence shows FIFO order and back-to-back out_valid.
REQ-039 Hold out_ready=0 with out_valid=1 -> req=0 for all requesters, out_data stable; release -> req reasserts the same cycle.
REQ-040 Drive gnt=4'b0011, then gnt=4'b1000 with requester 3 empty -> no pop, no out_valid change, gnt_err=1 and sticky.
REQ-041 Requester 1 at count 2, push and grant in the same cycle -> count stays 2, order preserved; en=0 -> req=0 while pushes still accepted.
REQ-042 Assert reset (low) mid-stream with out_valid=1 -> out_valid, req and gnt_err clear immediately without a clock; push_ready=4'b1111.
